// File: rtl/collision_pkg.sv
// Shared types, default hitbox geometry and helpers for the collision scanner.
package collision_pkg;

  // Scanner sequencing: wait for a frame, walk every channel, publish result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } scan_state_e;

  // Default obstacle hitbox relative to the obstacle offset.
  localparam int HIT_X_LO_DEF   = 10;
  localparam int HIT_X_HI_DEF   = 24;
  localparam int HIT_Y_SPAN_DEF = 32;

  // All-ones index value that flags a road-edge-only crash.
  function automatic logic [31:0] road_idx(input int idx_w);
    road_idx = (32'd1 << idx_w) - 32'd1;
  endfunction

endpackage

// File: rtl/collision_box_cmp.sv
// Single-channel hitbox test: is the player offset inside one obstacle's box?
// Terms are widened by one bit so obstacle + edge never wraps around.
module collision_box_cmp #(
  parameter int COORD_W    = 11,
  parameter int HIT_X_LO   = 10,
  parameter int HIT_X_HI   = 24,
  parameter int HIT_Y_SPAN = 32
) (
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [COORD_W-1:0] p_x,
  input  logic [COORD_W-1:0] p_y,
  output logic               hit
);

  localparam int EW = COORD_W + 1;

  logic [EW-1:0] obj_x_s;
  logic [EW-1:0] obj_y_s;
  logic [EW-1:0] p_x_s;
  logic [EW-1:0] p_y_s;
  logic [EW-1:0] x_lo_s;
  logic [EW-1:0] x_hi_s;
  logic [EW-1:0] y_hi_s;

  // Inclusive box bounds on widened operands, then the four-sided containment test.
  always_comb begin
    obj_x_s = {1'b0, obj_x};
    obj_y_s = {1'b0, obj_y};
    p_x_s   = {1'b0, p_x};
    p_y_s   = {1'b0, p_y};
    x_lo_s  = obj_x_s + EW'(HIT_X_LO);
    x_hi_s  = obj_x_s + EW'(HIT_X_HI);
    y_hi_s  = obj_y_s + EW'(HIT_Y_SPAN);
    hit     = (p_y_s >= obj_y_s) && (p_y_s <= y_hi_s) &&
              (p_x_s >= x_lo_s)  && (p_x_s <= x_hi_s);
  end

endmodule

// File: rtl/collision_scan_unit.sv
// Frame-rate player-vs-obstacle collision scanner for the road-fighter game.
// Snapshots all channels on startOfFrame, walks them one per clock through a
// shared comparator, and reports at most one crash per frame, gated by a
// frame-counted invulnerability window.
module collision_scan_unit
  import collision_pkg::*;
#(
  parameter int NUM_OBJ     = 7,
  parameter int COORD_W     = 11,
  parameter int HIT_X_LO    = HIT_X_LO_DEF,
  parameter int HIT_X_HI    = HIT_X_HI_DEF,
  parameter int HIT_Y_SPAN  = HIT_Y_SPAN_DEF,
  parameter int COOLDOWN_FR = 60,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startOfFrame,
  input  logic [COORD_W-1:0]           objOffsetX [NUM_OBJ],
  input  logic [COORD_W-1:0]           objOffsetY [NUM_OBJ],
  input  logic [NUM_OBJ-1:0]           objEnable,
  input  logic [COORD_W-1:0]           playerOffsetX,
  input  logic [COORD_W-1:0]           playerOffsetY,
  input  logic                         road_collision,
  output logic                         collision,
  output logic [$clog2(NUM_OBJ):0]     collisionIdx,
  output logic                         invulnerable,
  output logic [CNT_W-1:0]             hitCount,
  output logic                         scanOverrun
);

  localparam int IDX_W = $clog2(NUM_OBJ) + 1;
  localparam int CD_W  = (COOLDOWN_FR > 0) ? $clog2(COOLDOWN_FR + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
  localparam logic [IDX_W-1:0] ROAD_IDX = IDX_W'(road_idx(IDX_W));
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_FR);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  scan_state_e        state_r, state_nxt_s;
  logic [COORD_W-1:0] snap_x_r [NUM_OBJ];
  logic [COORD_W-1:0] snap_y_r [NUM_OBJ];
  logic [NUM_OBJ-1:0] snap_en_r;
  logic [COORD_W-1:0] snap_px_r, snap_py_r;
  logic               snap_road_r;
  logic [IDX_W-1:0]   idx_r, hit_idx_r;
  logic               hit_found_r;
  logic [CD_W-1:0]    cooldown_r, cooldown_nxt_s;
  logic               collision_r, invuln_r, overrun_r;
  logic [IDX_W-1:0]   coll_idx_r;
  logic [CNT_W-1:0]   hit_count_r;
  logic [COORD_W-1:0] sel_x_s, sel_y_s;
  logic               sel_en_s, box_hit_s, report_s;

  assign collision    = collision_r;
  assign collisionIdx = coll_idx_r;
  assign invulnerable = invuln_r;
  assign hitCount     = hit_count_r;
  assign scanOverrun  = overrun_r;

  // Scan mux: pick the snapshot of the channel currently being tested.
  always_comb begin
    sel_x_s  = {COORD_W{1'b0}};
    sel_y_s  = {COORD_W{1'b0}};
    sel_en_s = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      sel_x_s  = sel_x_s  | (snap_x_r[i] & {COORD_W{idx_r == IDX_W'(i)}});
      sel_y_s  = sel_y_s  | (snap_y_r[i] & {COORD_W{idx_r == IDX_W'(i)}});
      sel_en_s = sel_en_s | (snap_en_r[i] & (idx_r == IDX_W'(i)));
    end
  end

  collision_box_cmp #(
    .COORD_W    (COORD_W),
    .HIT_X_LO   (HIT_X_LO),
    .HIT_X_HI   (HIT_X_HI),
    .HIT_Y_SPAN (HIT_Y_SPAN)
  ) u_box_cmp (
    .obj_x (sel_x_s),
    .obj_y (sel_y_s),
    .p_x   (snap_px_r),
    .p_y   (snap_py_r),
    .hit   (box_hit_s)
  );

  // Next state, report qualification and next cooldown value.
  always_comb begin
    state_nxt_s    = state_r;
    report_s       = 1'b0;
    cooldown_nxt_s = cooldown_r;
    case (state_r)
      IDLE: begin
        if (startOfFrame) state_nxt_s = SCAN;
        else              state_nxt_s = IDLE;
      end
      SCAN: begin
        if (idx_r == LAST_IDX) state_nxt_s = REPORT;
        else                   state_nxt_s = SCAN;
      end
      REPORT: begin
        state_nxt_s = IDLE;
        report_s    = (hit_found_r | snap_road_r) && (cooldown_r == {CD_W{1'b0}});
      end
      default: state_nxt_s = IDLE;
    endcase
    // A fresh load from a reported crash takes precedence over the frame tick.
    if (report_s) begin
      cooldown_nxt_s = CD_LOAD;
    end else if (startOfFrame && (cooldown_r != {CD_W{1'b0}})) begin
      cooldown_nxt_s = cooldown_r - CD_W'(1'b1);
    end else begin
      cooldown_nxt_s = cooldown_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Frame snapshot, scan index and first-hit capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        snap_x_r[i] <= {COORD_W{1'b0}};
        snap_y_r[i] <= {COORD_W{1'b0}};
      end
      snap_en_r   <= {NUM_OBJ{1'b0}};
      snap_px_r   <= {COORD_W{1'b0}};
      snap_py_r   <= {COORD_W{1'b0}};
      snap_road_r <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      hit_idx_r   <= {IDX_W{1'b0}};
      hit_found_r <= 1'b0;
    end else if (state_r == IDLE && startOfFrame) begin
      snap_x_r    <= objOffsetX;
      snap_y_r    <= objOffsetY;
      snap_en_r   <= objEnable;
      snap_px_r   <= playerOffsetX;
      snap_py_r   <= playerOffsetY;
      snap_road_r <= road_collision;
      idx_r       <= {IDX_W{1'b0}};
      hit_found_r <= 1'b0;
    end else if (state_r == SCAN) begin
      idx_r <= idx_r + IDX_W'(1'b1);
      if (box_hit_s && sel_en_s && !hit_found_r) begin
        hit_idx_r   <= idx_r;
        hit_found_r <= 1'b1;
      end
    end
  end

  // Registered outputs: crash pulse, index, saturating count, cooldown, overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      collision_r <= 1'b0;
      coll_idx_r  <= {IDX_W{1'b0}};
      hit_count_r <= {CNT_W{1'b0}};
      cooldown_r  <= {CD_W{1'b0}};
      invuln_r    <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      collision_r <= report_s;
      cooldown_r  <= cooldown_nxt_s;
      invuln_r    <= (cooldown_nxt_s != {CD_W{1'b0}});
      if (report_s) begin
        coll_idx_r <= hit_found_r ? hit_idx_r : ROAD_IDX;
        if (hit_count_r != CNT_MAX) hit_count_r <= hit_count_r + CNT_W'(1'b1);
      end
      if (startOfFrame && state_r != IDLE) overrun_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_collision_scan_unit.sv
// Scoreboard bench for collision_scan_unit: directed frames plus randomized
// frames, checked against a frame-level behavioural model.
module tb_collision_scan_unit;

  localparam int N   = 7;
  localparam int CD  = 3;
  localparam int CMX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sof = 1'b0;
  logic [10:0] ox [N];
  logic [10:0] oy [N];
  logic [N-1:0] en = '0;
  logic [10:0] px = '0, py = '0;
  logic        road = 1'b0;
  logic        collision, invulnerable, scanOverrun;
  logic [3:0]  collisionIdx;
  logic [3:0]  hitCount;

  typedef struct { int cyc; int idx; int cnt; } exp_t;
  exp_t exp_q[$];
  exp_t x_m;

  int cyc = 0;
  int n_checks = 0, n_pass = 0;
  int m_cd = 0, m_cnt = 0, m_last = 0;
  bit m_ovr = 0;

  collision_scan_unit #(.COOLDOWN_FR(CD), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .objOffsetX(ox), .objOffsetY(oy), .objEnable(en),
    .playerOffsetX(px), .playerOffsetY(py), .road_collision(road),
    .collision(collision), .collisionIdx(collisionIdx), .invulnerable(invulnerable),
    .hitCount(hitCount), .scanOverrun(scanOverrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every crash pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (collision === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'(collision), 0);
      end else begin
        x_m = exp_q.pop_front();
        chk("pulse_cycle", cyc, x_m.cyc);
        chk("pulse_idx", int'(collisionIdx), x_m.idx);
        chk("pulse_count", int'(hitCount), x_m.cnt);
      end
    end
  end

  // Reference: lowest enabled obstacle whose inclusive box contains the player.
  task automatic model_hit(output bit any, output int idx);
    any = 0; idx = 0;
    for (int i = 0; i < N; i++) begin
      if (!any && en[i] &&
          int'(py) >= int'(oy[i]) && int'(py) <= int'(oy[i]) + 32 &&
          int'(px) >= int'(ox[i]) + 10 && int'(px) <= int'(ox[i]) + 24) begin
        any = 1; idx = i;
      end
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      ox[i] = 11'($urandom); oy[i] = 11'($urandom);
    end
    en = 7'($urandom); px = 11'($urandom); py = 11'($urandom); road = 1'($urandom);
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_collision"}, int'(collision), 0);
    chk({tag, "_idx"}, int'(collisionIdx), 0);
    chk({tag, "_invuln"}, int'(invulnerable), 0);
    chk({tag, "_count"}, int'(hitCount), 0);
    chk({tag, "_overrun"}, int'(scanOverrun), 0);
  endtask

  task automatic model_clear();
    m_cd = 0; m_cnt = 0; m_last = 0; m_ovr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sof = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check_idle_state("reset");
  endtask

  task automatic set_far();
    for (int i = 0; i < N; i++) begin
      ox[i] = 11'd1500; oy[i] = 11'd1500;
    end
    en = '1; road = 1'b0; px = 11'd100; py = 11'd200;
  endtask

  // One frame: SOF at the current negedge, optional overrun SOF mid-scan.
  task automatic run_frame(input bit ovr_f);
    bit any; int idx; int e; bit crash;
    model_hit(any, idx);
    crash = any | road;
    sof = 1'b1;
    e = cyc + 1;
    if (m_cd > 0) m_cd--;
    @(negedge clk);
    sof = 1'b0;
    scramble();
    if (ovr_f) begin
      repeat (2) @(negedge clk);
      sof = 1'b1; m_ovr = 1;
      if (m_cd > 0) m_cd--;
      @(negedge clk);
      sof = 1'b0;
    end
    if (crash && m_cd == 0) begin
      m_cnt  = (m_cnt < CMX) ? m_cnt + 1 : CMX;
      m_last = any ? idx : 15;
      m_cd   = CD;
      exp_q.push_back('{e + 8, m_last, m_cnt});
    end
    while (cyc < e + 8) @(negedge clk);
    chk("frame_invuln", int'(invulnerable), (m_cd != 0) ? 1 : 0);
    chk("frame_count", int'(hitCount), m_cnt);
    chk("frame_overrun", int'(scanOverrun), int'(m_ovr));
    chk("frame_idx_hold", int'(collisionIdx), m_last);
  endtask

  task automatic directed_one(input int i, input int x, input int y, input int p_x, input int p_y);
    do_reset();
    set_far();
    ox[i] = 11'(x); oy[i] = 11'(y); px = 11'(p_x); py = 11'(p_y);
    run_frame(0);
  endtask

  initial begin
    int e;
    for (int i = 0; i < N; i++) begin ox[i] = '0; oy[i] = '0; end
    do_reset();

    // Basic hit on obstacle 3.
    directed_one(3, 80, 180, 100, 200);
    // Two hitting obstacles: lowest index wins.
    do_reset(); set_far();
    ox[2] = 11'd80; oy[2] = 11'd180; ox[5] = 11'd80; oy[5] = 11'd180;
    run_frame(0);
    // Road edge only.
    do_reset(); set_far(); road = 1'b1;
    run_frame(0);
    // Hitbox edges, inside and just outside, and no wrap at the top of range.
    directed_one(1, 90, 180, 100, 200);
    directed_one(1, 76, 180, 100, 200);
    directed_one(1, 80, 168, 100, 200);
    directed_one(1, 91, 180, 100, 200);
    directed_one(1, 75, 180, 100, 200);
    directed_one(1, 80, 167, 100, 200);
    directed_one(1, 2040, 180, 10, 200);
    // Disabled hitting channel.
    do_reset(); set_far();
    ox[4] = 11'd80; oy[4] = 11'd180; en[4] = 1'b0;
    run_frame(0);
    // Cooldown sequence with repeated hits, including an overrun frame.
    do_reset();
    for (int f = 0; f < 6; f++) begin
      set_far(); ox[3] = 11'd80; oy[3] = 11'd180;
      run_frame(f == 1);
    end
    // Reset in the fourth scan cycle aborts the frame without a pulse.
    do_reset(); set_far(); ox[3] = 11'd80; oy[3] = 11'd180;
    sof = 1'b1; e = cyc + 1;
    @(negedge clk); sof = 1'b0;
    while (cyc < e + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_clear();
    check_idle_state("midscan_reset");
    repeat (10) @(negedge clk);
    chk("midscan_no_pulse_count", int'(hitCount), 0);
    set_far(); ox[0] = 11'd80; oy[0] = 11'd180;
    run_frame(0);

    // Randomized frames.
    for (int f = 0; f < 300; f++) begin
      px = 11'($urandom_range(40, 2000));
      py = 11'($urandom_range(40, 2000));
      for (int i = 0; i < N; i++) begin
        en[i] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 5) == 0) begin
          ox[i] = 11'(int'(px) - int'($urandom_range(8, 26)));
          oy[i] = 11'(int'(py) - int'($urandom_range(0, 34)));
        end else begin
          ox[i] = 11'($urandom); oy[i] = 11'($urandom);
        end
      end
      road = ($urandom_range(0, 9) == 0);
      run_frame($urandom_range(0, 19) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("missing_pulses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
